// File: rtl/vga_bar_renderer.sv
// rtl/vga_bar_renderer.sv - VGA timing generator and segmented spectrum-bar renderer
//
// Generates VGA sync/blank timing on the pixel clock and draws NUM_BARS segmented
// bars with colour zones and peak-hold markers. Heights are captured into a shadow
// register on HEIGHT_VALID and copied to the displayed set once per frame at the
// start of vertical blanking, so a frame never shows a mix of old and new heights.
//
// Ports:
//   VGA_CLK       in   pixel clock
//   RESET_N       in   asynchronous active-low reset
//   HEIGHT        in   packed per-bar heights, bar b at [b*HEIGHT_W +: HEIGHT_W]
//   HEIGHT_VALID  in   strobe, loads HEIGHT into the shadow register
//   MODE          in   00 bars, 01 peaks, 10 bars+peaks, 11 off (sampled at frame swap)
//   VGA_HS/VGA_VS out  active-low syncs, aligned with RGB
//   ADV_BLANK_N   out  high in the visible area
//   ADV_SYNC_N    out  tied low
//   VGA_R/G/B     out  pixel colour
//   FRAME_START   out  one-cycle pulse aligned with the frame-swap cycle
module vga_bar_renderer #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int NUM_BARS    = 20,
    parameter int BAR_PITCH   = 32,
    parameter int BAR_GAP     = 2,
    parameter int SEG_H       = 10,
    parameter int SEG_GAP     = 2,
    parameter int HEIGHT_W    = 6,
    parameter int RED_SEGS    = 3,
    parameter int ORANGE_SEGS = 7,
    parameter int PEAK_HOLD   = 30,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic                         VGA_CLK,
    input  logic                         RESET_N,
    input  logic [NUM_BARS*HEIGHT_W-1:0] HEIGHT,
    input  logic                         HEIGHT_VALID,
    input  logic [1:0]                   MODE,
    output logic                         VGA_HS,
    output logic                         VGA_VS,
    output logic                         ADV_BLANK_N,
    output logic                         ADV_SYNC_N,
    output logic [7:0]                   VGA_R,
    output logic [7:0]                   VGA_G,
    output logic [7:0]                   VGA_B,
    output logic                         FRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_SEG = V_ACTIVE / SEG_H;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int COL_W   = $clog2(BAR_PITCH + 1);
    localparam int BAR_W   = $clog2(NUM_BARS + 1);
    localparam int ROW_W   = $clog2(SEG_H + 1);
    localparam int SEG_W   = $clog2(MAX_SEG + 1);
    localparam int HOLD_W  = $clog2(PEAK_HOLD + 1);

    // ---------------- stage 0: counters ----------------
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic [COL_W-1:0] col;
    logic [BAR_W-1:0] bar_idx;
    logic [ROW_W-1:0] row;
    logic [SEG_W-1:0] seg;
    logic             line_end, frame_end, swap;

    assign line_end  = (h_cnt == H_W'(H_TOTAL - 1));
    assign frame_end = (v_cnt == V_W'(V_TOTAL - 1));
    assign swap      = (h_cnt == '0) && (v_cnt == V_W'(V_ACTIVE));

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            col     <= '0;
            bar_idx <= '0;
            row     <= '0;
            seg     <= '0;
        end else if (line_end) begin
            h_cnt   <= '0;
            col     <= '0;
            bar_idx <= '0;
            if (frame_end) begin
                v_cnt <= '0;
                row   <= '0;
                seg   <= SEG_W'(MAX_SEG);
            end else begin
                v_cnt <= v_cnt + 1'b1;
                if (row == ROW_W'(SEG_H - 1)) begin
                    row <= '0;
                    // seg stops at 0 below the active area; 0 is never drawn
                    if (seg != '0)
                        seg <= seg - 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
            if (col == COL_W'(BAR_PITCH - 1)) begin
                col <= '0;
                // saturate at NUM_BARS so columns right of the last bar stay dark
                if (bar_idx < BAR_W'(NUM_BARS))
                    bar_idx <= bar_idx + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---------------- shadow, displayed heights, peaks ----------------
    logic [NUM_BARS*HEIGHT_W-1:0] shadow;
    logic [SEG_W-1:0]             height_act [NUM_BARS];
    logic [SEG_W-1:0]             peak       [NUM_BARS];
    logic [SEG_W-1:0]             clamped    [NUM_BARS];
    logic [HOLD_W-1:0]            hold       [NUM_BARS];
    logic [1:0]                   mode_r;

    always_comb begin
        for (int b = 0; b < NUM_BARS; b++) begin
            if (32'(shadow[b*HEIGHT_W +: HEIGHT_W]) > MAX_SEG)
                clamped[b] = SEG_W'(MAX_SEG);
            else
                clamped[b] = SEG_W'(shadow[b*HEIGHT_W +: HEIGHT_W]);
        end
    end

    // The swap reads the shadow before this cycle's strobe lands, so a strobe
    // on the swap cycle only shows up one frame later.
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow <= '0;
            mode_r <= 2'b00;
            for (int b = 0; b < NUM_BARS; b++) begin
                height_act[b] <= '0;
                peak[b]       <= '0;
                hold[b]       <= '0;
            end
        end else begin
            if (HEIGHT_VALID)
                shadow <= HEIGHT;
            if (swap) begin
                mode_r <= MODE;
                for (int b = 0; b < NUM_BARS; b++) begin
                    height_act[b] <= clamped[b];
                    if (clamped[b] >= peak[b]) begin
                        peak[b] <= clamped[b];
                        hold[b] <= HOLD_W'(PEAK_HOLD);
                    end else if (hold[b] != '0) begin
                        hold[b] <= hold[b] - 1'b1;
                    end else if (peak[b] != '0) begin
                        peak[b] <= peak[b] - 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stage 1: per-bar mux ----------------
    logic [SEG_W-1:0] hgt_sel, pk_sel;

    always_comb begin
        hgt_sel = '0;
        pk_sel  = '0;
        for (int b = 0; b < NUM_BARS; b++) begin
            if (bar_idx == BAR_W'(b)) begin
                hgt_sel = height_act[b];
                pk_sel  = peak[b];
            end
        end
    end

    logic             s1_hs, s1_vs, s1_vis, s1_elig, s1_fs;
    logic [SEG_W-1:0] s1_seg, s1_hgt, s1_pk;

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_vis  <= 1'b0;
            s1_elig <= 1'b0;
            s1_fs   <= 1'b0;
            s1_seg  <= '0;
            s1_hgt  <= '0;
            s1_pk   <= '0;
        end else begin
            s1_hs   <= !(h_cnt >= H_W'(H_ACTIVE + H_FP) && h_cnt < H_W'(H_ACTIVE + H_FP + H_SYNC));
            s1_vs   <= !(v_cnt >= V_W'(V_ACTIVE + V_FP) && v_cnt < V_W'(V_ACTIVE + V_FP + V_SYNC));
            s1_vis  <= (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
            s1_elig <= (col < COL_W'(BAR_PITCH - BAR_GAP)) && (bar_idx < BAR_W'(NUM_BARS))
                       && (row >= ROW_W'(SEG_GAP)) && (seg != '0);
            s1_fs   <= swap;
            s1_seg  <= seg;
            s1_hgt  <= hgt_sel;
            s1_pk   <= pk_sel;
        end
    end

    // ---------------- stage 2: colour and output registers ----------------
    logic        draw_bars, draw_peaks, bar_lit, peak_lit;
    logic [23:0] pix;

    always_comb begin
        draw_bars  = (mode_r == 2'b00) || (mode_r == 2'b10);
        draw_peaks = (mode_r == 2'b01) || (mode_r == 2'b10);
        bar_lit    = draw_bars && (s1_seg <= s1_hgt);
        peak_lit   = draw_peaks && (s1_pk != '0) && (s1_seg == s1_pk)
                     && ((mode_r == 2'b01) || (s1_pk > s1_hgt));
        pix        = BG_COLOR;
        if (!s1_vis) begin
            pix = 24'h000000;
        end else if (s1_elig) begin
            if (peak_lit)
                pix = 24'hFFFFFF;
            else if (bar_lit) begin
                if (32'(s1_seg) > MAX_SEG - RED_SEGS)
                    pix = 24'hFF0000;
                else if (32'(s1_seg) > MAX_SEG - RED_SEGS - ORANGE_SEGS)
                    pix = 24'hFF7500;
                else
                    pix = 24'h00FF00;
            end
        end
    end

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            ADV_BLANK_N <= 1'b0;
            FRAME_START <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else begin
            VGA_HS      <= s1_hs;
            VGA_VS      <= s1_vs;
            ADV_BLANK_N <= s1_vis;
            FRAME_START <= s1_fs;
            VGA_R       <= pix[23:16];
            VGA_G       <= pix[15:8];
            VGA_B       <= pix[7:0];
        end
    end

    assign ADV_SYNC_N = 1'b0;

endmodule

// File: doc/vga_bar_renderer.md
# vga_bar_renderer

Parametrised VGA timing generator and spectrum-bar renderer for the audio visualiser, clocked on the pixel clock. It accepts a packed vector of per-bar heights and latches it once per frame in vertical blanking, so bars never tear. It draws segmented bars with colour zones and per-bar peak-hold markers selected by a mode input, and emits sync, blank and RGB to the ADV video DAC.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (line total 800)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (frame total 525)
- NUM_BARS, 20, bar count; requires NUM_BARS*BAR_PITCH <= H_ACTIVE
- BAR_PITCH, 32, pixels per bar column; BAR_GAP 2, unlit rightmost columns of each pitch
- SEG_H, 10, lines per segment; SEG_GAP 2, unlit top lines of each segment; V_ACTIVE % SEG_H == 0
- HEIGHT_W, 6, bits per height; MAX_SEG = V_ACTIVE/SEG_H (48)
- RED_SEGS, 3 and ORANGE_SEGS, 7, top colour-zone sizes in segments
- PEAK_HOLD, 30, frames a peak is held before it decays
- BG_COLOR, 24'h000000, background RGB
- VGA_CLK  in  1  pixel clock, the only clock
- RESET_N  in  1  asynchronous, active-low reset
- HEIGHT  in  NUM_BARS*HEIGHT_W  packed heights; bar b = HEIGHT[b*HEIGHT_W +: HEIGHT_W], bar 0 leftmost
- HEIGHT_VALID  in  1  single-cycle strobe; HEIGHT is captured into the shadow register
- MODE  in  2  00 bars, 01 peaks only, 10 bars+peaks, 11 display off (background only)
- VGA_HS, VGA_VS  out  1  active-low syncs
- ADV_BLANK_N  out  1  high in the visible area
- ADV_SYNC_N  out  1  constant 0 (sync-on-green unused)
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- FRAME_START  out  1  one-cycle pulse on the frame-swap cycle

## Operation
- Counters: h counts 0..H_TOTAL-1; on wrap, v counts 0..V_TOTAL-1 and wraps to 0.
- HS is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751. VS is low for v in [V_ACTIVE+V_FP, +V_SYNC), i.e. 490..491. BLANK_N is high for h<H_ACTIVE and v<V_ACTIVE.
- Shadow: HEIGHT_VALID loads the shadow register from HEIGHT. The last strobe before the swap wins.
- Frame swap happens on the cycle with h=0, v=V_ACTIVE. On that cycle:
  - active heights load from the shadow, each clamped to MAX_SEG;
  - MODE is sampled;
  - peaks update;
  - FRAME_START pulses.
- A strobe on the swap cycle updates the shadow only. The swap uses the prior shadow, and the new value is shown one frame later.
- Peak update per bar, with h = the new clamped height:
  - if h >= peak: peak = h and hold = PEAK_HOLD;
  - else if hold > 0: hold decrements;
  - else if peak > 0: peak decrements by 1.
- Column tracking uses counters, not division. bar_idx and col advance with h. col wraps at BAR_PITCH, and bar_idx increments on the wrap. A pixel is lit-eligible when col < BAR_PITCH-BAR_GAP and bar_idx < NUM_BARS.
- Row tracking: seg loads MAX_SEG and row = 0 at v=0. row increments each line and wraps at SEG_H, and seg decrements on the wrap. A pixel is lit-eligible when row >= SEG_GAP. Segment 1 is the bottom segment.
- Pixel colour, in the visible area and eligible:
  - bar lit when the mode draws bars and seg <= height[bar_idx];
  - peak lit when the mode draws peaks, peak[bar_idx] > 0, seg == peak[bar_idx] and peak > height (mode 10) or unconditionally (mode 01).
- Colour priority: peak gives FFFFFF. Otherwise a lit bar takes its zone colour: seg > MAX_SEG-RED_SEGS gives FF0000; seg > MAX_SEG-RED_SEGS-ORANGE_SEGS gives FF7500; anything lower gives 00FF00. Otherwise BG_COLOR. Outside the visible area RGB = 0.
- Reset (asynchronous, any time, including mid-frame):
  - h and v counters, bar/column/segment counters, heights, shadow, peaks, hold counters and MODE register clear to 0;
  - VGA_HS = VGA_VS = 1, ADV_BLANK_N = 0, RGB = 0, FRAME_START = 0.
- After reset release, the next frame's display shows no bars until the first swap.

## Timing
- Three-stage pipeline:
  - stage 0: counters;
  - stage 1: height/peak mux by bar_idx and compare;
  - stage 2: output registers.
- The counter state (h,v) appears on all outputs (HS, VS, BLANK_N, RGB) aligned, exactly 2 cycles later. The syncs are delayed to match RGB.
- FRAME_START is registered with the same 2-cycle alignment as the swap cycle.
- Line = 800 cycles. Frame = 420000 cycles. The first swap occurs at counter cycle 480*800 = 384000 after reset release.

## Test plan
- Reset and sync timing: release RESET_N at cycle 0, so the counter is at (0,0) on cycle 0. Outputs must be HS=1, VS=1, BLANK_N=0, RGB=0 before and during reset. HS must be low on cycles 658..753 of each line. VS must be low for lines 490..491 (offset 2 cycles). BLANK_N must fall at cycle 642.
- Single bar: strobe HEIGHT with bar0=1 and all others 0 in MODE 00, before the swap. In the next frame, x 0..29 at y 472..479 must be 00FF00. x 30..31, y 470..471 and bar1 must be BG.
- Clamp and zones: bar3 = 63. bar3 must be lit at all 48 segments. y=2 (seg 48) must be FF0000, seg 42 must be FF7500, seg 38 must be 00FF00.
- Peak hold and decay, in MODE 10: bar0 = 10 for one frame, then 0. A white marker must sit at seg 10 (y 382..389) for 30 frames, then drop one segment per frame, and be absent 10 frames later.
- Swap boundary: strobe HEIGHT_VALID exactly on the swap cycle with bar0=5, while the shadow holds bar0=2. The next frame must show 2, and the frame after that 5. MODE changed mid-frame must take effect only at the swap.
- Reset mid-frame: assert RESET_N low at (300,200). All state must clear within 0 cycles (asynchronous). After release, the counters must restart at (0,0) with no bars shown.
